// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field layout, node geometry, hop computation and packetizer FSM states.
package noc_pkg;

  localparam int unsigned PKT_W      = 57;
  localparam int unsigned NODE_W     = 4;
  localparam int unsigned PSUM_W     = 13;
  localparam int unsigned PKT_ADDR_W = 27;
  localparam int unsigned HOP_W      = 3;

  localparam int unsigned TYPE_BIT  = 56;
  localparam int unsigned SRC_LSB   = 52;
  localparam int unsigned DST_LSB   = 48;
  localparam int unsigned X_DIR_BIT = 47;
  localparam int unsigned X_HOP_LSB = 44;
  localparam int unsigned Y_DIR_BIT = 43;
  localparam int unsigned Y_HOP_LSB = 40;
  localparam int unsigned ADDR_LSB  = 13;
  localparam int unsigned PSUM_LSB  = 0;

  localparam logic TYPE_PSUM = 1'b1;

  typedef struct packed {
    logic             x_dir;
    logic [HOP_W-1:0] x_hop;
    logic             y_dir;
    logic [HOP_W-1:0] y_hop;
  } hops_t;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_DONE = 1'b1
  } state_e;

  // Node coords are x = id[1:0], y = id[3:2]; dir set when travelling toward lower coordinate.
  function automatic hops_t calc_hops(input logic [NODE_W-1:0] src, input logic [NODE_W-1:0] dst);
    hops_t      h;
    logic [1:0] sx, sy, dx, dy;
    sx      = src[1:0];
    sy      = src[3:2];
    dx      = dst[1:0];
    dy      = dst[3:2];
    h.x_dir = (dx < sx);
    h.x_hop = h.x_dir ? HOP_W'(sx - dx) : HOP_W'(dx - sx);
    h.y_dir = (dy < sy);
    h.y_hop = h.y_dir ? HOP_W'(sy - dy) : HOP_W'(dy - sy);
    return h;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous shift-style FIFO; entry 0 is always the head so read data comes straight from a flop.
module pkt_fifo #(
  parameter int unsigned WIDTH = 57,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;
  logic [CNT_W-1:0] wr_slot;

  always_comb begin
    mem_d   = mem_q;
    do_pop  = pop && !empty_q;
    do_push = push && !full_q;
    wr_slot = cnt_q;
    if (do_pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_slot = cnt_q - CNT_W'(1);
    end
    if (do_push) begin
      mem_d[IDX_W'(wr_slot)] = wdata;
    end
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign rdata = mem_q[0];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/psum_packetizer.sv
// Tags PE partial sums with address/source/route fields and streams them as NoC packets,
// enforcing the per-timestep 0..DEPTH_C-1 address order and the layer-completion handshake.
module psum_packetizer
  import noc_pkg::*;
#(
  parameter int unsigned      DEPTH_C    = 441,
  parameter int unsigned      ADDR_C     = 9,
  parameter logic [NODE_W-1:0] SRC_TS1   = 4'd13,
  parameter logic [NODE_W-1:0] SRC_TS2   = 4'd14,
  parameter logic [NODE_W-1:0] DEST_ID   = 4'd15,
  parameter int unsigned      FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_data,
  input  logic              psum_ts,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data,
  input  logic              layer_done,
  output logic              ts1_sent,
  output logic              ts2_sent
);

  localparam logic [ADDR_C-1:0] LAST_ADDR = ADDR_C'(DEPTH_C - 1);

  state_e                  state_q, state_d;
  logic [1:0][ADDR_C-1:0]  addr_cnt_q, addr_cnt_d;
  logic [1:0]              ts_done_q, ts_done_d;
  logic                    fifo_full, fifo_empty;
  logic                    psum_acc, pkt_pop;
  logic [NODE_W-1:0]       src_id;
  hops_t                   hops;
  logic [PKT_W-1:0]        pkt_c;

  assign psum_ready = !rst && !fifo_full && (state_q == RUN) && !ts_done_q[psum_ts];
  assign psum_acc   = psum_valid && psum_ready;
  assign pkt_valid  = !rst && !fifo_empty;
  assign pkt_pop    = pkt_valid && pkt_ready;
  assign ts1_sent   = ts_done_q[0];
  assign ts2_sent   = ts_done_q[1];

  // Packet formation for the psum currently offered.
  assign src_id = psum_ts ? SRC_TS2 : SRC_TS1;
  assign hops   = calc_hops(src_id, DEST_ID);

  always_comb begin
    pkt_c                            = '0;
    pkt_c[TYPE_BIT]                  = TYPE_PSUM;
    pkt_c[SRC_LSB +: NODE_W]         = src_id;
    pkt_c[DST_LSB +: NODE_W]         = DEST_ID;
    pkt_c[X_DIR_BIT]                 = hops.x_dir;
    pkt_c[X_HOP_LSB +: HOP_W]        = hops.x_hop;
    pkt_c[Y_DIR_BIT]                 = hops.y_dir;
    pkt_c[Y_HOP_LSB +: HOP_W]        = hops.y_hop;
    pkt_c[ADDR_LSB +: PKT_ADDR_W]    = PKT_ADDR_W'(addr_cnt_q[psum_ts]);
    pkt_c[PSUM_LSB +: PSUM_W]        = psum_data;
  end

  // Counters saturate at the last address; only layer completion rewinds them.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    ts_done_d  = ts_done_q;
    unique case (state_q)
      RUN: begin
        if (psum_acc) begin
          if (addr_cnt_q[psum_ts] == LAST_ADDR) begin
            ts_done_d[psum_ts] = 1'b1;
          end else begin
            addr_cnt_d[psum_ts] = addr_cnt_q[psum_ts] + ADDR_C'(1);
          end
        end
        if ((&ts_done_q) && fifo_empty) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (layer_done) begin
          state_d    = RUN;
          addr_cnt_d = '0;
          ts_done_d  = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      addr_cnt_q <= '0;
      ts_done_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      ts_done_q  <= ts_done_d;
    end
  end

  pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (psum_acc),
    .wdata (pkt_c),
    .pop   (pkt_pop),
    .rdata (pkt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_psum_packetizer.sv
// Scoreboarded bench for psum_packetizer (DEPTH_C = 4) with a field-level reference model.
module tb_psum_packetizer;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              psum_valid;
  logic              psum_ready;
  logic [12:0]       psum_data;
  logic              psum_ts;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [56:0]       pkt_data;
  logic              layer_done;
  logic              ts1_sent;
  logic              ts2_sent;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [56:0]       exp_q[$];
  logic [56:0]       exp_head;
  int                m_cnt[2];
  int                rdy_mode = 1;

  psum_packetizer #(.DEPTH_C(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_ts    (psum_ts),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .layer_done (layer_done),
    .ts1_sent   (ts1_sent),
    .ts2_sent   (ts2_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packet built from node coordinates with plain integer arithmetic.
  function automatic logic [56:0] exp_pkt(input bit ts, input int addr, input logic [12:0] d);
    int src, dst, sx, sy, dx, dy, xh, yh;
    bit xd, yd;
    src = ts ? 14 : 13;
    dst = 15;
    sx = src % 4; sy = src / 4;
    dx = dst % 4; dy = dst / 4;
    xd = (dx < sx);
    yd = (dy < sy);
    xh = (dx > sx) ? dx - sx : sx - dx;
    yh = (dy > sy) ? dy - sy : sy - dy;
    return {1'b1, 4'(src), 4'(dst), xd, 3'(xh), yd, 3'(yh), 27'(addr), d};
  endfunction

  task automatic model_accept(input bit ts, input logic [12:0] d);
    exp_q.push_back(exp_pkt(ts, (m_cnt[ts] < DEPTH) ? m_cnt[ts] : DEPTH - 1, d));
    if (m_cnt[ts] < DEPTH) m_cnt[ts]++;
  endtask

  task automatic model_clear();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Scoreboard monitor: every delivered packet must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", pkt_data, 0);
      end else begin
        exp_head = exp_q.pop_front();
        check("pkt", pkt_data, exp_head);
      end
    end
  end

  // Router ready driver: 0 = stalled, 1 = always ready, 2 = random.
  initial begin
    pkt_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pkt_ready = 1'b0;
        1:       pkt_ready = 1'b1;
        default: pkt_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic send_chk(input string name, input bit ts, input logic [12:0] d,
                          input int budget, input bit exp_acc);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    psum_valid = 1'b1;
    psum_ts    = ts;
    psum_data  = d;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (psum_ready) begin
        acc = 1'b1;
        model_accept(ts, d);
      end
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    check(name, acc, exp_acc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_layer_done();
    @(posedge clk); #1;
    layer_done = 1'b1;
    @(posedge clk); #1;
    layer_done = 1'b0;
  endtask

  // Random interleaved stream until both timesteps are complete, then the done handshake.
  task automatic random_layer();
    rdy_mode = 2;
    for (int it = 0; it < 200 && !(m_cnt[0] >= DEPTH && m_cnt[1] >= DEPTH); it++) begin
      automatic bit ts = 1'($urandom_range(0, 1));
      automatic bit dn = (m_cnt[ts] >= DEPTH);
      send_chk(dn ? "refuse_done_ts" : "accept_rand", ts, 13'($urandom), dn ? 3 : 40, !dn);
      check("ts1_sent", ts1_sent, (m_cnt[0] >= DEPTH));
      check("ts2_sent", ts2_sent, (m_cnt[1] >= DEPTH));
    end
    check("layer_complete", (m_cnt[0] >= DEPTH) && (m_cnt[1] >= DEPTH), 1);
    send_chk("ts1_5th_refused", 1'b0, 13'h1abc, 3, 1'b0);
    rdy_mode = 1;
    wait_drain();
    repeat (3) @(negedge clk);
    check("state_wait_done", dut.state_q, WAIT_DONE);
    @(posedge clk); #1;
    psum_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      psum_ts = 1'(t);
      @(negedge clk);
      check("wait_done_ready_low", psum_ready, 0);
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    pulse_layer_done();
    model_clear();
    @(negedge clk);
    check("ts1_sent_cleared", ts1_sent, 0);
    check("ts2_sent_cleared", ts2_sent, 0);
    check("state_run", dut.state_q, RUN);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psum_valid = 1'b0; psum_data = '0; psum_ts = 1'b0; layer_done = 1'b0;
    model_clear();

    // Reset state
    @(negedge clk);
    check("rst_psum_ready", psum_ready, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pkt_data", pkt_data, 0);
    check("post_rst_ts1", ts1_sent, 0);
    check("post_rst_ts2", ts2_sent, 0);
    check("post_rst_ready", psum_ready, 1);

    // Single ts1 psum, field-level check
    send_chk("single_accept", 1'b0, 13'd100, 5, 1'b1);
    @(negedge clk);
    check("single_valid", pkt_valid, 1);
    check("single_type", pkt_data[56], 1);
    check("single_src", pkt_data[55:52], 13);
    check("single_dst", pkt_data[51:48], 15);
    check("single_hops", pkt_data[47:40], 8'h20);
    check("single_addr", pkt_data[39:13], 0);
    check("single_psum", pkt_data[12:0], 100);
    wait_drain();

    // Backpressure: fill the FIFO, refuse the fifth, head holds steady
    rdy_mode = 0;
    send_chk("bp_acc0", 1'b1, 13'd11, 5, 1'b1);
    send_chk("bp_acc1", 1'b1, 13'd12, 5, 1'b1);
    send_chk("bp_acc2", 1'b1, 13'd13, 5, 1'b1);
    send_chk("bp_acc3", 1'b0, 13'd14, 5, 1'b1);
    send_chk("bp_full_refuse", 1'b1, 13'd15, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_head_stable", pkt_data, exp_q[0]);
      check("bp_head_valid", pkt_valid, 1);
    end
    rdy_mode = 1;
    wait_drain();

    // Complete the first layer with a random interleave
    random_layer();
    rdy_mode = 1;
    send_chk("post_layer_ts2", 1'b1, 13'd77, 5, 1'b1);
    @(negedge clk);
    check("post_layer_addr", pkt_data[39:13], 0);
    check("post_layer_src", pkt_data[55:52], 14);
    wait_drain();

    // layer_done during RUN must not disturb the counters
    pulse_layer_done();
    send_chk("run_ld_ts2", 1'b1, 13'd78, 5, 1'b1);
    @(negedge clk);
    check("run_ld_addr", pkt_data[39:13], 1);
    wait_drain();

    // Second full layer
    random_layer();

    // Reset with three packets buffered
    rdy_mode = 1;
    send_chk("pre_rst_ts1", 1'b0, 13'd5, 5, 1'b1);
    wait_drain();
    rdy_mode = 0;
    send_chk("buf0", 1'b0, 13'd21, 5, 1'b1);
    send_chk("buf1", 1'b1, 13'd22, 5, 1'b1);
    send_chk("buf2", 1'b0, 13'd23, 5, 1'b1);
    @(negedge clk);
    check("buf_valid", pkt_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", psum_ready, 0);
    check("midrst_valid", pkt_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    check("after_rst_valid", pkt_valid, 0);
    check("after_rst_data", pkt_data, 0);
    check("after_rst_ts1", ts1_sent, 0);
    check("after_rst_ts2", ts2_sent, 0);
    rdy_mode = 1;
    send_chk("after_rst_ts2_acc", 1'b1, 13'd300, 5, 1'b1);
    @(negedge clk);
    check("after_rst_src", pkt_data[55:52], 14);
    check("after_rst_addr", pkt_data[39:13], 0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_packetizer.md
Name: psum_packetizer

Overview:
- Synchronous transmit-side packetizer at a conv PE cluster.
- Accepts 13-bit partial sums from the PE datapath and tags each with its psum address, timestep source ID and XY hop fields.
- Emits 57-bit NoC packets toward the output memory node.
- Enforces the output-memory ordering contract: per timestep, addresses run strictly 0..DEPTH_C-1. After both timesteps are complete, the block stalls until the output memory signals layer completion.

Parameters:
- DEPTH_C, 441, psums per timestep (output feature map size).
- ADDR_C, 9, psum address counter width.
- SRC_TS1, 13, node ID used as source field for timestep-1 psums.
- SRC_TS2, 14, node ID used as source field for timestep-2 psums.
- DEST_ID, 15, output memory node ID.
- FIFO_DEPTH, 4, packet buffer entries (power of 2).
- PSUM_W, 13, psum width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- psum_valid  in  1  PE psum valid
- psum_ready  out  1  packetizer can accept psum
- psum_data  in  13  partial sum value
- psum_ts  in  1  0 = timestep 1, 1 = timestep 2
- pkt_valid  out  1  packet valid toward router
- pkt_ready  in  1  router accepts packet
- pkt_data  out  57  packet
- layer_done  in  1  one-cycle pulse from output memory: both timesteps consumed
- ts1_sent  out  1  all DEPTH_C ts1 psums accepted
- ts2_sent  out  1  all DEPTH_C ts2 psums accepted

Behaviour:
- Packet format (shared package):
  - [56] type, 1 = psum.
  - [55:52] source.
  - [51:48] dest.
  - [47] x_dir, [46:44] x_hop, [43] y_dir, [42:40] y_hop.
  - [39:13] psum address, zero-extended from ADDR_C to 27 bits.
  - [12:0] psum.
- Node coords: x = id[1:0], y = id[3:2].
  - dir = 1 when dest coord < source coord; hop = |dest - source|.
  - All four fields are computed combinationally from the selected source ID and DEST_ID.
- Accept: a psum is accepted on a cycle with psum_valid && psum_ready.
  - psum_ready = !fifo_full && state == RUN && !ts_done[psum_ts].
  - Accept writes the formed packet into the FIFO.
  - Accept increments addr_cnt[psum_ts].
- Address counters:
  - When addr_cnt[ts] == DEPTH_C-1 on accept, set tsN_sent and hold the counter at DEPTH_C-1.
  - No wrap occurs until layer_done.
  - Both counters are independent, so interleaved ts1/ts2 streams are legal.
- FIFO: registered output. pkt_valid = !fifo_empty; pkt_data = head entry.
  - Pop on pkt_valid && pkt_ready.
  - Simultaneous push and pop when full: push is blocked, because psum_ready is computed from the pre-pop full flag.
  - Simultaneous push and pop when non-full: both occur, count unchanged.
  - Latency: psum accept at cycle N gives pkt_valid at N+1 if the FIFO was empty.
- FSM:
  - RUN → WAIT_DONE when ts1_sent && ts2_sent && fifo_empty.
  - WAIT_DONE → RUN on layer_done. This clears both counters, ts1_sent and ts2_sent.
  - layer_done in RUN is ignored.
  - In WAIT_DONE, psum_ready = 0.
- Reset (rst high at a clock edge, including mid-packet):
  - psum_ready = 0 for the reset cycle, pkt_valid = 0.
  - pkt_data = 0, FIFO pointers = 0, counters = 0.
  - ts1_sent = 0, ts2_sent = 0, state = RUN.
  - Undelivered packets are discarded.
- pkt_data/pkt_valid stable while pkt_valid && !pkt_ready.

Decomposition:
- Shared package noc_pkg:
  - packet field localparams (bit positions above), PKT_W = 57.
  - node ID width 4.
  - function calc_hops(src, dst) returning {x_dir, x_hop, y_dir, y_hop}.
  - typedef enum {RUN, WAIT_DONE}.
- One sub-module: pkt_fifo (parameterised width/depth synchronous FIFO with full/empty).

Test Plan:
- Single ts1 psum 100 with router ready:
  - One cycle later, pkt_data source = 13, dest = 15, addr = 0, [12:0] = 100, type = 1.
  - Hop fields: x_dir = 0, x_hop = 2, y_dir = 0, y_hop = 0.
- Backpressure: pkt_ready held low, push 5 psums.
  - 4 accepted, psum_ready drops.
  - Head pkt_data stable.
  - Release pkt_ready: packets exit in order with addr 0..3.
- Full layer, DEPTH_C = 4 override, interleaved ts1/ts2 psums:
  - Each timestep gets addr 0..3.
  - ts1_sent and ts2_sent assert on the 4th accept of each.
  - A 5th ts1 psum is refused.
  - State reaches WAIT_DONE after drain.
- In WAIT_DONE, psum_valid high: psum_ready stays 0.
  - layer_done pulse: next accepted psum has addr 0, tsN_sent cleared.
- Reset mid-stream with 3 packets buffered:
  - Next cycle pkt_valid = 0, counters 0.
  - First post-reset ts2 psum gives source = 14, addr = 0.
- layer_done pulsed in RUN before completion: no effect on counters.
